// File: rtl/ws2812_frame_arbiter.sv
// rtl/ws2812_frame_arbiter.sv - frame-level round-robin arbiter sharing one WS2812 byte serializer
//
// Grants one ready source at a time, streams exactly LEDS*3 bytes from it,
// waits for the serializer to drain, then holds a latch gap before re-arbitrating.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   src_enable         per-source enable mask
//   src_trigger        per-source "frame ready" level
//   src_color          packed bytes, source i at [8i+7:8i]
//   src_data_request   one-hot pulse to the granted source when its byte is consumed
//   tx_byte            byte presented to the serializer (0 outside STREAM)
//   tx_byte_request    serializer consumes tx_byte this cycle
//   tx_busy            serializer still shifting
//   grant_valid        a source owns the serializer (STREAM/DRAIN/LATCH)
//   grant_id           index of owning source
//   frame_done         pulse at the end of a normal latch gap
//   frame_abort        pulse when the serializer stalls for TIMEOUT cycles
module ws2812_frame_arbiter #(
    parameter int NSRC         = 4,
    parameter int LEDS         = 128,
    parameter int LATCH_CYCLES = 2500,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_enable,
    input  logic [NSRC-1:0]         src_trigger,
    input  logic [8*NSRC-1:0]       src_color,
    output logic [NSRC-1:0]         src_data_request,
    output logic [7:0]              tx_byte,
    input  logic                    tx_byte_request,
    input  logic                    tx_busy,
    output logic                    grant_valid,
    output logic [$clog2(NSRC)-1:0] grant_id,
    output logic                    frame_done,
    output logic                    frame_abort
);

    localparam int IDW   = $clog2(NSRC);
    localparam int FRAME = LEDS * 3;
    localparam int BW    = $clog2(FRAME);
    localparam int LW    = $clog2(LATCH_CYCLES);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0]  BYTE_LAST  = BW'(FRAME - 1);
    localparam logic [LW-1:0]  LATCH_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [TW-1:0]  IDLE_MAX   = TW'(TIMEOUT);
    localparam logic [IDW-1:0] SRC_LAST   = IDW'(NSRC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        LATCH  = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [IDW-1:0] last_grant;
    logic [BW-1:0]  byte_cnt;
    logic [TW-1:0]  idle_cnt;
    logic [LW-1:0]  latch_cnt;
    logic           aborted;

    logic [NSRC-1:0] ready;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            timeout;

    // Round-robin search starting just after the previous owner, wrapping.
    always_comb begin
        ready = src_trigger & src_enable;
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NSRC; i++) begin
            cand = IDW'((int'(last_grant) + i) % NSRC);
            if (!found && ready[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Abort has priority over a request arriving on the same cycle.
    assign timeout = (state == STREAM) && (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        tx_byte          = '0;
        src_data_request = '0;
        frame_done       = 1'b0;
        frame_abort      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                for (int i = 0; i < NSRC; i++) begin
                    if (grant_id == IDW'(i)) begin
                        tx_byte = src_color[8*i +: 8];
                    end
                end
                if (timeout) begin
                    frame_abort = 1'b1;
                    state_next  = LATCH;
                end else if (tx_byte_request) begin
                    src_data_request[grant_id] = 1'b1;
                    if (byte_cnt == BYTE_LAST) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (!tx_busy && latch_cnt == LATCH_LAST) begin
                    state_next = IDLE;
                    frame_done = !aborted;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_grant  <= SRC_LAST;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            latch_cnt   <= '0;
            aborted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_valid <= 1'b1;
                        grant_id    <= pick;
                        last_grant  <= pick;
                        aborted     <= 1'b0;
                        byte_cnt    <= '0;
                        idle_cnt    <= '0;
                    end
                end
                STREAM: begin
                    if (timeout) begin
                        // last_grant stays on the aborted source so it goes to the back of the line.
                        aborted   <= 1'b1;
                        latch_cnt <= '0;
                        byte_cnt  <= '0;
                        idle_cnt  <= '0;
                    end else if (tx_byte_request) begin
                        idle_cnt <= '0;
                        byte_cnt <= (byte_cnt == BYTE_LAST) ? '0 : byte_cnt + 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    latch_cnt <= '0;
                end
                LATCH: begin
                    if (tx_busy) begin
                        latch_cnt <= '0;
                    end else if (latch_cnt == LATCH_LAST) begin
                        latch_cnt   <= '0;
                        grant_valid <= 1'b0;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// tb/tb_ws2812_frame_arbiter.sv - self-checking bench for ws2812_frame_arbiter
module tb_ws2812_frame_arbiter;

    localparam int NSRC  = 4;
    localparam int LEDS  = 4;
    localparam int LC    = 200;
    localparam int TO    = 4096;
    localparam int FRAME = LEDS * 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NSRC-1:0]   src_enable = '0;
    logic [NSRC-1:0]   src_trigger = '0;
    logic [8*NSRC-1:0] src_color = '0;
    logic [NSRC-1:0]   src_data_request;
    logic [7:0]        tx_byte;
    logic              tx_byte_request = 1'b0;
    logic              tx_busy = 1'b0;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              frame_done;
    logic              frame_abort;

    int asserts = 0;
    int fails   = 0;
    int m_last  = NSRC - 1;

    always #5 clk = ~clk;

    ws2812_frame_arbiter #(
        .NSRC(NSRC), .LEDS(LEDS), .LATCH_CYCLES(LC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .src_enable(src_enable), .src_trigger(src_trigger), .src_color(src_color),
        .src_data_request(src_data_request), .tx_byte(tx_byte),
        .tx_byte_request(tx_byte_request), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    // First ready source strictly after 'last', wrapping; -1 if none.
    function automatic int rr_pick(input logic [NSRC-1:0] rdy, input int last);
        for (int k = 1; k <= NSRC; k++) begin
            if (rdy[(last + k) % NSRC]) return (last + k) % NSRC;
        end
        return -1;
    endfunction

    // Observes one complete grant: wait, stream FRAME bytes (or stall into abort),
    // drain, latch gap, and the single idle cycle that follows.
    task automatic run_frame(input int stall_after, input int glitch_at, output int got_id);
        int exp_id, phase, reqs, idle, gap, drain_left, glitch_left;
        bit aborted, glitched, exp_abort, exp_done;
        logic [7:0] exp_byte;
        logic [NSRC-1:0] exp_req;
        exp_id = rr_pick(src_trigger & src_enable, m_last);
        got_id = -1;
        phase = 0; reqs = 0; idle = 0; gap = 0;
        aborted = 1'b0; glitched = 1'b0; glitch_left = 0;
        drain_left = $urandom_range(0, 6);
        for (int cyc = 0; cyc < TO + 3 * LC + 400 && phase != 5; cyc++) begin
            @(negedge clk);
            src_color = $urandom;
            case (phase)
                0: begin tx_byte_request = 1'($urandom_range(0, 1)); tx_busy = 1'b0; end
                1: begin
                    tx_byte_request = (stall_after >= 0 && reqs >= stall_after) ? 1'b0
                                      : ($urandom_range(0, 3) != 0);
                    tx_busy = (reqs > 0);
                end
                2: begin
                    tx_byte_request = 1'($urandom_range(0, 1));
                    tx_busy = (drain_left > 0);
                    if (drain_left > 0) drain_left--;
                end
                3: begin
                    tx_byte_request = 1'($urandom_range(0, 1));
                    if (glitch_at > 0 && !glitched && gap == glitch_at) begin
                        glitched = 1'b1;
                        glitch_left = 3;
                    end
                    tx_busy = (glitch_left > 0);
                    if (glitch_left > 0) glitch_left--;
                end
                default: begin tx_byte_request = 1'($urandom_range(0, 1)); tx_busy = 1'b0; end
            endcase
            #1;
            if (phase == 0 && grant_valid) begin
                asserts++;
                if (grant_id !== 2'(exp_id)) begin
                    fails++;
                    $display("FAIL grant_id: got %0d expected %0d", grant_id, exp_id);
                end
                got_id = int'(grant_id);
                m_last = exp_id;
                phase = 1;
                idle = 0;
            end
            case (phase)
                0: begin
                    asserts++;
                    if (src_data_request !== '0 || tx_byte !== 8'd0 || frame_done !== 1'b0 || frame_abort !== 1'b0) begin
                        fails++;
                        $display("FAIL idle_outputs: req=%b byte=%h done=%b abort=%b expected all 0",
                                 src_data_request, tx_byte, frame_done, frame_abort);
                    end
                end
                1: begin
                    exp_abort = (idle == TO);
                    exp_byte  = src_color[8*exp_id +: 8];
                    exp_req   = (tx_byte_request && !exp_abort) ? (NSRC'(1) << exp_id) : '0;
                    asserts++;
                    if (src_data_request !== exp_req) begin
                        fails++;
                        $display("FAIL stream_request: got %b expected %b (byte %0d)", src_data_request, exp_req, reqs);
                    end
                    asserts++;
                    if (tx_byte !== exp_byte) begin
                        fails++;
                        $display("FAIL stream_tx_byte: got %h expected %h", tx_byte, exp_byte);
                    end
                    asserts++;
                    if (frame_abort !== exp_abort || frame_done !== 1'b0 || grant_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL stream_flags: abort=%b done=%b gv=%b expected abort=%b done=0 gv=1",
                                 frame_abort, frame_done, grant_valid, exp_abort);
                    end
                    if (exp_abort) begin
                        aborted = 1'b1;
                        phase = 3;
                        gap = 0;
                    end else if (tx_byte_request) begin
                        reqs++;
                        idle = 0;
                        if (reqs == FRAME) phase = 2;
                    end else begin
                        idle++;
                    end
                end
                2: begin
                    asserts++;
                    if (src_data_request !== '0 || frame_done !== 1'b0 || frame_abort !== 1'b0 || grant_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL drain_outputs: req=%b done=%b abort=%b gv=%b expected 0,0,0,1",
                                 src_data_request, frame_done, frame_abort, grant_valid);
                    end
                    if (!tx_busy) begin
                        phase = 3;
                        gap = 0;
                    end
                end
                3: begin
                    if (tx_busy) gap = 0;
                    else gap++;
                    exp_done = !aborted && (gap == LC);
                    asserts++;
                    if (frame_done !== exp_done) begin
                        fails++;
                        $display("FAIL latch_frame_done: got %b expected %b at gap %0d", frame_done, exp_done, gap);
                    end
                    asserts++;
                    if (src_data_request !== '0 || frame_abort !== 1'b0 || grant_valid !== 1'b1 || tx_byte !== 8'd0) begin
                        fails++;
                        $display("FAIL latch_outputs: req=%b abort=%b gv=%b byte=%h expected 0,0,1,00",
                                 src_data_request, frame_abort, grant_valid, tx_byte);
                    end
                    if (gap == LC) phase = 4;
                end
                4: begin
                    asserts++;
                    if (grant_valid !== 1'b0 || frame_done !== 1'b0 || src_data_request !== '0) begin
                        fails++;
                        $display("FAIL post_latch_idle: gv=%b done=%b req=%b expected 0,0,0",
                                 grant_valid, frame_done, src_data_request);
                    end
                    phase = 5;
                end
                default: ;
            endcase
        end
        asserts++;
        if (phase != 5) begin
            fails++;
            $display("FAIL frame_timeout: stuck in phase %0d expected completion", phase);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        src_enable = 4'hF;
        src_trigger = 4'hF;
        tx_byte_request = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        asserts++;
        if (grant_valid !== 1'b0 || grant_id !== 2'd0 || src_data_request !== '0 ||
            tx_byte !== 8'd0 || frame_done !== 1'b0 || frame_abort !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: gv=%b id=%0d req=%b byte=%h done=%b abort=%b expected all 0",
                     grant_valid, grant_id, src_data_request, tx_byte, frame_done, frame_abort);
        end
        src_trigger = '0;
        rst = 1'b1;
        m_last = NSRC - 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            asserts++;
            if (grant_valid !== 1'b0 || src_data_request !== '0) begin
                fails++;
                $display("FAIL no_trigger_idle: gv=%b req=%b expected 0", grant_valid, src_data_request);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        int id;
        src_enable = 4'hF;
        src_trigger = 4'hF;
        for (int i = 0; i < 5; i++) begin
            run_frame(-1, -1, id);
            asserts++;
            if (id !== exp_ids[i]) begin
                fails++;
                $display("FAIL rr_order: frame %0d got %0d expected %0d", i, id, exp_ids[i]);
            end
        end
    endtask

    task automatic test_enable_mask();
        int exp_ids[4] = '{1, 3, 1, 3};
        int id;
        src_enable = 4'b1010;
        src_trigger = 4'hF;
        for (int i = 0; i < 4; i++) begin
            run_frame(-1, -1, id);
            asserts++;
            if (id !== exp_ids[i]) begin
                fails++;
                $display("FAIL mask_order: frame %0d got %0d expected %0d", i, id, exp_ids[i]);
            end
        end
    endtask

    task automatic test_single_source();
        int id;
        src_enable = 4'hF;
        src_trigger = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            run_frame(-1, -1, id);
            asserts++;
            if (id !== 0) begin
                fails++;
                $display("FAIL single_grant: got %0d expected 0", id);
            end
        end
    endtask

    task automatic test_abort();
        int id_a, id_b;
        src_enable = 4'hF;
        src_trigger = 4'hF;
        run_frame(5, -1, id_a);
        run_frame(-1, -1, id_b);
        asserts++;
        if (id_b !== (id_a + 1) % NSRC) begin
            fails++;
            $display("FAIL abort_next_grant: got %0d expected %0d", id_b, (id_a + 1) % NSRC);
        end
    endtask

    task automatic test_latch_restart();
        int id;
        src_enable = 4'hF;
        src_trigger = 4'hF;
        run_frame(-1, 100, id);
    endtask

    task automatic test_reset_mid_frame();
        int reqs, id;
        bit granted;
        src_enable = 4'hF;
        src_trigger = 4'b0001;
        reqs = 0;
        granted = 1'b0;
        for (int cyc = 0; cyc < 100 && reqs < 7; cyc++) begin
            @(negedge clk);
            tx_byte_request = 1'b1;
            #1;
            if (grant_valid) granted = 1'b1;
            if (src_data_request[0]) reqs++;
        end
        asserts++;
        if (!granted || reqs != 7) begin
            fails++;
            $display("FAIL midframe_setup: granted=%b reqs=%0d expected 1,7", granted, reqs);
        end
        @(negedge clk);
        tx_byte_request = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        asserts++;
        if (grant_valid !== 1'b0 || grant_id !== 2'd0 || src_data_request !== '0 ||
            tx_byte !== 8'd0 || frame_done !== 1'b0 || frame_abort !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: gv=%b id=%0d req=%b byte=%h done=%b abort=%b expected all 0",
                     grant_valid, grant_id, src_data_request, tx_byte, frame_done, frame_abort);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        m_last = NSRC - 1;
        src_trigger = 4'hF;
        run_frame(-1, -1, id);
        asserts++;
        if (id !== 0) begin
            fails++;
            $display("FAIL post_reset_grant: got %0d expected 0", id);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_enable_mask();
        test_single_source();
        test_abort();
        test_latch_restart();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
